// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NREQ bursting producers
module fifo_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   gnt,
  input  logic              fifo_full,
  output logic              fifo_write_en,
  output logic [DW-1:0]     fifo_data_in,
  output logic [IDW-1:0]    src_id,
  output logic              busy
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state;
  logic [IDW-1:0] owner, last_win, sel, idx;
  logic [3:0] burst_cnt;
  logic own, xfer, rel;
  assign own = state == OWN;
  assign xfer = own && req[owner] && !fifo_full;
  assign rel = own && (!req[owner] || (xfer && (req_last[owner] || burst_cnt == 4'(MAX_BURST - 1))));
  assign fifo_write_en = xfer;
  assign fifo_data_in = own ? DW'(req_data >> (int'(owner) * DW)) : '0;
  assign ack = xfer ? NREQ'(1) << owner : '0;
  assign src_id = own ? owner : '0;
  assign busy = own;
  // scanning downwards lets the requester closest after last_win win
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last_win) + k) % NREQ);
      if (req[idx]) sel = idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      last_win <= IDW'(NREQ - 1);
      burst_cnt <= '0;
      gnt <= '0;
    end else if (!own) begin
      if (|req) begin
        state <= OWN;
        owner <= sel;
        burst_cnt <= '0;
        gnt <= NREQ'(1) << sel;
      end
    end else if (rel) begin
      state <= IDLE;
      last_win <= owner;
      gnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: producer models feed the arbiter; writes are scored against an expected-word queue
module tb_fifo_wr_arbiter;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [3:0] req = 0, req_last = 0;
  logic [31:0] req_data = 0;
  logic fifo_full = 0;
  logic [3:0] ack, gnt, ack2, gnt2;
  logic we, we2, busy, busy2;
  logic [7:0] din, din2;
  logic [1:0] sid, sid2;
  typedef logic [8:0] word_t;
  word_t src [4][$];
  logic [9:0] expq[$], exp2[$], me, e2;
  int checks = 0, errors = 0;
  bit sb_on = 0;

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .gnt(gnt), .fifo_full(fifo_full), .fifo_write_en(we),
    .fifo_data_in(din), .src_id(sid), .busy(busy)
  );

  fifo_wr_arbiter #(.MAX_BURST(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack2), .gnt(gnt2), .fifo_full(fifo_full), .fifo_write_en(we2),
    .fifo_data_in(din2), .src_id(sid2), .busy(busy2)
  );

  always @(negedge clk) begin
    if (sb_on && we) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: write id=%0d data=%h with nothing expected", sid, din);
      end else begin
        me = expq.pop_front();
        if ({sid, din} !== me || ack !== (4'b0001 << me[9:8]) || fifo_full) begin
          errors++;
          $display("FAIL sb_word: id=%0d data=%h ack=%b full=%b, required id=%0d data=%h", sid, din, ack, fifo_full, me[9:8], me[7:0]);
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = src[i].size() > 0;
      req_last[i] = req[i] ? src[i][0][8] : 1'b0;
      req_data[i*8 +: 8] = req[i] ? src[i][0][7:0] : 8'h00;
    end
  endtask

  task automatic step(input logic [3:0] a);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (a[i] && src[i].size() > 0) void'(src[i].pop_front());
    drive();
  endtask

  task automatic load(input int i, input logic [7:0] base, input int n, input bit last_on_end);
    for (int k = 0; k < n; k++) src[i].push_back({last_on_end && k == n - 1, base + 8'(k)});
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) expq.push_back({id, base + 8'(k)});
  endtask

  task automatic do_reset();
    rst = 1;
    fifo_full = 0;
    for (int i = 0; i < 4; i++) src[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_reset();
    req = 4'hF;
    req_last = 4'hF;
    req_data = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({ack, gnt, we, din, sid, busy} !== 20'h0 || {ack2, gnt2, we2, din2, sid2, busy2} !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs: dut=%h dut2=%h required 0", {ack, gnt, we, din, sid, busy}, {ack2, gnt2, we2, din2, sid2, busy2});
      end
    end
    do_reset();
  endtask

  task automatic test_priority();
    logic [3:0] pat [11];
    pat = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
    for (int i = 0; i < 4; i++) begin
      load(i, 8'hA0 + 8'(i), 1, 1);
      push(2'(i), 8'hA0 + 8'(i), 1);
    end
    load(0, 8'hB0, 1, 1);
    push(2'd0, 8'hB0, 1);
    sb_on = 1;
    drive();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== pat[c] || ack !== pat[c]) begin
        errors++;
        $display("FAIL priority c%0d: gnt=%b ack=%b, required %b", c, gnt, ack, pat[c]);
      end
      step(ack);
    end
  endtask

  task automatic test_burst();
    logic [0:15] wp, bp;
    wp = 16'b0111101111011000;
    bp = 16'b0111101111011100;
    load(2, 8'h20, 10, 0);
    push(2'd2, 8'h20, 10);
    drive();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      checks++;
      if (we !== wp[c] || busy !== bp[c] || sid !== (bp[c] ? 2'd2 : 2'd0)) begin
        errors++;
        $display("FAIL burst c%0d: we=%b busy=%b src_id=%0d, required we=%b busy=%b", c, we, busy, sid, wp[c], bp[c]);
      end
      step(ack);
    end
  endtask

  task automatic test_stall();
    logic [0:8] wp;
    wp = 9'b011000110;
    load(1, 8'h10, 4, 1);
    push(2'd1, 8'h10, 4);
    drive();
    for (int c = 0; c < 9; c++) begin
      fifo_full = c >= 3 && c <= 5;
      @(negedge clk);
      checks++;
      if (ack !== (wp[c] ? 4'b0010 : 4'b0000) || we !== wp[c]) begin
        errors++;
        $display("FAIL stall c%0d: ack=%b we=%b, required we=%b", c, ack, we, wp[c]);
      end
      if (fifo_full) begin
        checks++;
        if (din !== 8'h12 || dut.burst_cnt !== 4'd2 || gnt !== 4'b0010) begin
          errors++;
          $display("FAIL stall_hold c%0d: data=%h burst_cnt=%0d gnt=%b, required 12 2 0010", c, din, dut.burst_cnt, gnt);
        end
      end
      step(ack);
    end
    fifo_full = 0;
  endtask

  task automatic test_withdraw();
    logic [0:5] wp;
    logic [3:0] gp [6];
    wp = 6'b010010;
    gp = '{4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h0};
    load(3, 8'h33, 1, 0);
    load(0, 8'h40, 1, 1);
    push(2'd3, 8'h33, 1);
    push(2'd0, 8'h40, 1);
    drive();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (we !== wp[c] || gnt !== gp[c]) begin
        errors++;
        $display("FAIL withdraw c%0d: we=%b gnt=%b, required we=%b gnt=%b", c, we, gnt, wp[c], gp[c]);
      end
      if (c == 3) begin
        checks++;
        if (dut.last_win !== 2'd3) begin
          errors++;
          $display("FAIL withdraw_last_win: last_win=%0d, required 3", dut.last_win);
        end
      end
      step(ack);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] gp [13];
    gp = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0};
    do_reset();
    sb_on = 0;
    load(0, 8'hA0, 4, 0);
    load(2, 8'hC0, 4, 0);
    exp2 = '{{2'd0, 8'hA0}, {2'd0, 8'hA1}, {2'd2, 8'hC0}, {2'd2, 8'hC1},
             {2'd0, 8'hA2}, {2'd0, 8'hA3}, {2'd2, 8'hC2}, {2'd2, 8'hC3}};
    drive();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      checks++;
      if (gnt2 !== gp[c]) begin
        errors++;
        $display("FAIL fair_gnt c%0d: gnt=%b, required %b", c, gnt2, gp[c]);
      end
      if (we2) begin
        checks++;
        e2 = exp2.size() > 0 ? exp2.pop_front() : 10'h3FF;
        if ({sid2, din2} !== e2) begin
          errors++;
          $display("FAIL fair_word c%0d: id=%0d data=%h, required id=%0d data=%h", c, sid2, din2, e2[9:8], e2[7:0]);
        end
      end
      step(ack2);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] gp [7];
    gp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    do_reset();
    sb_on = 1;
    load(1, 8'h51, 3, 0);
    push(2'd1, 8'h51, 1);
    drive();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (c == 0 ? 4'b0000 : 4'b0010)) begin
        errors++;
        $display("FAIL rmid_gnt c%0d: gnt=%b", c, gnt);
      end
      step(ack);
    end
    checks++;
    if (ack !== 4'b0010 || we !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: ack=%b we=%b, required 0010 1", ack, we);
    end
    load(0, 8'h50, 1, 1);
    drive();
    rst = 1;
    #1;
    checks++;
    if ({ack, gnt, we, din, sid, busy} !== 20'h0) begin
      errors++;
      $display("FAIL rmid_outputs: %h, required 0", {ack, gnt, we, din, sid, busy});
    end
    @(posedge clk);
    #1 rst = 0;
    push(2'd0, 8'h50, 1);
    push(2'd1, 8'h52, 2);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== gp[c]) begin
        errors++;
        $display("FAIL rmid_after c%0d: gnt=%b, required %b", c, gnt, gp[c]);
      end
      step(ack);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_burst();
    test_stall();
    test_withdraw();
    test_fairness();
    test_reset_mid();
    checks++;
    if (expq.size() != 0 || exp2.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d and %0d expected words never written, required 0", expq.size(), exp2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
